// File: rtl/lift_motion_pkg.sv
// -----------------------------------------------------------------------------
// lift_motion_pkg
// Shared types and widths for the per-lift motion stage.
//   motor_cmd_e     - 2-bit motor command coming from the elevator controller
//   motion_state_e  - motion FSM states
//   FLOOR_W/DUTY_W  - floor index and PWM duty widths
//   travel_cmd()    - command that keeps the lift moving in a given direction
// -----------------------------------------------------------------------------
package lift_motion_pkg;

   localparam int FLOOR_W = 4;
   localparam int DUTY_W  = 8;

   typedef enum logic [1:0] {
      CMD_STOP = 2'b00,
      CMD_UP   = 2'b01,
      CMD_DOWN = 2'b10,
      CMD_DOOR = 2'b11
   } motor_cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      REL,
      ACC,
      RUN,
      DEC,
      HOLD,
      DOOR,
      FAULT
   } motion_state_e;

   // The only command that lets travel continue in direction `up`.
   function automatic motor_cmd_e travel_cmd(input logic up);
      return up ? CMD_UP : CMD_DOWN;
   endfunction

endpackage

// File: rtl/lift_pwm_gen.sv
// -----------------------------------------------------------------------------
// lift_pwm_gen
// Free-running 8-bit PWM generator with a registered output.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   duty  in   compare value; 0 gives a constant-low output
//   pwm   out  registered (counter < duty)
// -----------------------------------------------------------------------------
module lift_pwm_gen
   import lift_motion_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm
);

   logic [DUTY_W-1:0] cnt_q, cnt_d;
   logic              pwm_q, pwm_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      pwm_d = (cnt_q < duty);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/lift_motion_ctrl.sv
// -----------------------------------------------------------------------------
// lift_motion_ctrl
// Per-lift motion stage: turns the 2-bit motor command into PWM drive,
// direction, brake and door actuation, and tracks the current floor from a
// hall-effect floor-sensor pulse.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   motor_signal  in   command: 00 STOP, 01 UP, 10 DOWN, 11 DOOR
//   floor_pulse   in   asynchronous floor sensor, rising edge counts
//   motor_pwm     out  PWM motor drive
//   motor_dir     out  1 = up, 0 = down (changes only when leaving IDLE)
//   brake         out  1 = brake engaged
//   door_open     out  1 = door actuator open
//   cur_floor     out  tracked floor index 0..MAX_FLOOR
//   busy          out  FSM not in IDLE
//   fault         out  sticky watchdog fault
// Build option: define LIFT_MOTION_WDOG_EN to add the floor-pulse watchdog and
// the FAULT state; without it fault is tied low.
// -----------------------------------------------------------------------------
module lift_motion_ctrl
   import lift_motion_pkg::*;
#(
   parameter int MAX_FLOOR = 10,
   parameter int DUTY_MAX  = 200,
   parameter int RAMP_STEP = 4,
   parameter int BRAKE_CYC = 16,
   parameter int DOOR_CYC  = 64
`ifdef LIFT_MOTION_WDOG_EN
   ,
   parameter int WDOG_CYC  = 4096
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         motor_signal,
   input  logic               floor_pulse,
   output logic               motor_pwm,
   output logic               motor_dir,
   output logic               brake,
   output logic               door_open,
   output logic [FLOOR_W-1:0] cur_floor,
   output logic               busy,
   output logic               fault
);

   localparam int TMR_W = $clog2((DOOR_CYC > BRAKE_CYC) ? DOOR_CYC : BRAKE_CYC);

   localparam logic [TMR_W-1:0]   BRAKE_LAST = TMR_W'(BRAKE_CYC - 1);
   localparam logic [TMR_W-1:0]   DOOR_LAST  = TMR_W'(DOOR_CYC - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(MAX_FLOOR);
   localparam logic [DUTY_W-1:0]  DUTY_FULL  = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0]  STEP_D     = DUTY_W'(RAMP_STEP);
   localparam logic [DUTY_W-1:0]  UP_SAT     = DUTY_W'(DUTY_MAX - RAMP_STEP);

   motion_state_e      state_q, state_d;
   motor_cmd_e         cmd_q, cmd_d;
   logic [2:0]         sync_q, sync_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [DUTY_W-1:0]  duty_q, duty_d;
   logic               dir_q, dir_d;
   logic [FLOOR_W-1:0] floor_q, floor_d;
   logic               brake_q, brake_d;
   logic               door_q, door_d;
   logic               busy_q, busy_d;

   logic               fp_rise;
   logic               moving;
   logic               step;
   logic               at_limit;
   logic               stop_req;
   logic [DUTY_W-1:0]  duty_up, duty_dn;

`ifdef LIFT_MOTION_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

   logic [WDOG_W-1:0]  wdog_q, wdog_d;
   logic               fault_q, fault_d;
`endif

   // Input stage: command register plus a 2-FF synchroniser; the third stage
   // only remembers the previous synchronised level for edge detection.
   always_comb begin
      cmd_d  = motor_cmd_e'(motor_signal);
      sync_d = {sync_q[1:0], floor_pulse};
   end

   assign fp_rise = sync_q[1] & ~sync_q[2];

   // State register and all datapath flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cmd_q   <= CMD_STOP;
         sync_q  <= '0;
         tmr_q   <= '0;
         duty_q  <= '0;
         dir_q   <= 1'b0;
         floor_q <= '0;
         brake_q <= 1'b1;
         door_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef LIFT_MOTION_WDOG_EN
         wdog_q  <= '0;
         fault_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cmd_q   <= cmd_d;
         sync_q  <= sync_d;
         tmr_q   <= tmr_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         floor_q <= floor_d;
         brake_q <= brake_d;
         door_q  <= door_d;
         busy_q  <= busy_d;
`ifdef LIFT_MOTION_WDOG_EN
         wdog_q  <= wdog_d;
         fault_q <= fault_d;
`endif
      end
   end

   // Next-state, ramp, floor tracking and watchdog.
   always_comb begin
      // NOTE: defaults first so no branch can leave a signal unassigned (latch).
      state_d = state_q;
      tmr_d   = tmr_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      floor_d = floor_q;

      duty_up = (duty_q >= UP_SAT) ? DUTY_FULL : duty_q + STEP_D;
      duty_dn = (duty_q <= STEP_D) ? '0 : duty_q - STEP_D;

      // Floor edges only count while the cab is actually driven.
      moving = (state_q == ACC) || (state_q == RUN) || (state_q == DEC);
      step   = moving && fp_rise;
      if (step) begin
         if (dir_q) floor_d = (floor_q == TOP_FLOOR) ? TOP_FLOOR : floor_q + 1'b1;
         else       floor_d = (floor_q == '0)        ? '0        : floor_q - 1'b1;
      end
      // Arriving at the end floor stops travel even if the command persists.
      at_limit = step && (dir_q ? (floor_d == TOP_FLOOR) : (floor_d == '0));
      stop_req = (cmd_q != travel_cmd(dir_q)) || at_limit;

      case (state_q)
         IDLE: begin
            tmr_d = '0;
            case (cmd_q)
               CMD_UP: begin
                  if (floor_q != TOP_FLOOR) begin
                     state_d = REL;
                     dir_d   = 1'b1;
                  end
               end
               CMD_DOWN: begin
                  if (floor_q != '0) begin
                     state_d = REL;
                     dir_d   = 1'b0;
                  end
               end
               CMD_DOOR: state_d = DOOR;
               default:  state_d = IDLE;
            endcase
         end
         REL: begin
            if (stop_req) begin
               state_d = DEC;
               tmr_d   = '0;
            end else if (tmr_q == BRAKE_LAST) begin
               state_d = ACC;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ACC: begin
            if (stop_req) begin
               state_d = DEC;
            end else begin
               duty_d = duty_up;
               if (duty_up == DUTY_FULL) state_d = RUN;
            end
         end
         RUN: begin
            if (stop_req) state_d = DEC;
         end
         DEC: begin
            duty_d = duty_dn;
            if (duty_dn == '0) begin
               state_d = HOLD;
               tmr_d   = '0;
            end
         end
         HOLD: begin
            if (tmr_q == BRAKE_LAST) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         DOOR: begin
            if (tmr_q == DOOR_LAST) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         FAULT: begin
            duty_d = '0;
         end
      endcase

`ifdef LIFT_MOTION_WDOG_EN
      // Counts driven cycles since the last counted floor edge; overrides any
      // other transition once the limit is hit.
      wdog_d = '0;
      if (moving && !fp_rise) begin
         if (wdog_q == WDOG_LAST) begin
            state_d = FAULT;
            duty_d  = '0;
         end else begin
            wdog_d = wdog_q + 1'b1;
         end
      end
`endif
   end

   // Output decode from the next state so the registered outputs line up with
   // the state they describe.
   always_comb begin
      brake_d = (state_d == IDLE) || (state_d == HOLD) ||
                (state_d == DOOR) || (state_d == FAULT);
      door_d  = (state_d == DOOR);
      busy_d  = (state_d != IDLE);
`ifdef LIFT_MOTION_WDOG_EN
      fault_d = (state_d == FAULT);
`endif
   end

   // Compare against the next duty so PWM drops on the same edge as duty.
   lift_pwm_gen u_pwm (
      .clk  (clk),
      .rst  (rst),
      .duty (duty_d),
      .pwm  (motor_pwm)
   );

   assign motor_dir = dir_q;
   assign brake     = brake_q;
   assign door_open = door_q;
   assign cur_floor = floor_q;
   assign busy      = busy_q;
`ifdef LIFT_MOTION_WDOG_EN
   assign fault     = fault_q;
`else
   assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lift_motion_ctrl
// Directed and randomised stimulus for lift_motion_ctrl against a cycle-level
// reference model of the lift's motion rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lift_motion_ctrl;

   localparam int MAXF  = 10;
   localparam int DMAX  = 200;
   localparam int STEP  = 4;
   localparam int BRK   = 16;
   localparam int DOORC = 64;
`ifdef LIFT_MOTION_WDOG_EN
   localparam int WDOG  = 4096;
`endif

   localparam logic [1:0] C_STOP = 2'd0;
   localparam logic [1:0] C_UP   = 2'd1;
   localparam logic [1:0] C_DOWN = 2'd2;
   localparam logic [1:0] C_DOOR = 2'd3;

   logic       clk          = 1'b0;
   logic       rst          = 1'b0;
   logic [1:0] motor_signal = C_STOP;
   logic       floor_pulse  = 1'b0;
   logic       motor_pwm, motor_dir, brake, door_open, busy, fault;
   logic [3:0] cur_floor;

   lift_motion_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .motor_signal (motor_signal),
      .floor_pulse  (floor_pulse),
      .motor_pwm    (motor_pwm),
      .motor_dir    (motor_dir),
      .brake        (brake),
      .door_open    (door_open),
      .cur_floor    (cur_floor),
      .busy         (busy),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_errors = 0;
   string tag      = "reset";

   // Reference model: phase name, countdown timer, duty and floor as integers.
   string ph;
   int    timer, duty, floor_i, quiet, pwm_cnt, cmd_prev;
   bit    up, h1, h2, h3, e_pwm;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s/%s: observed %0d expected %0d", tag, name, obs, exp);
      end
   endtask

   task automatic m_reset();
      ph = "idle"; timer = 0; duty = 0; floor_i = 0; quiet = 0; pwm_cnt = 0;
      cmd_prev = 0; up = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; e_pwm = 1'b0;
   endtask

   // One clock edge of the lift rules, using the command seen one edge earlier
   // and a floor edge seen through two synchroniser stages.
   task automatic m_step(input int c, input bit fp);
      bit fe, moving, limit, stop;
      fe     = h2 && !h3;
      moving = (ph == "accel") || (ph == "run") || (ph == "decel");
      limit  = 1'b0;
      if (fe && moving) begin
         if (up) floor_i = (floor_i < MAXF) ? floor_i + 1 : MAXF;
         else    floor_i = (floor_i > 0) ? floor_i - 1 : 0;
         limit = up ? (floor_i == MAXF) : (floor_i == 0);
      end
      stop = (cmd_prev != (up ? 1 : 2)) || limit;

      if (ph == "idle") begin
         if (cmd_prev == 1 && floor_i < MAXF) begin ph = "release"; up = 1'b1; timer = BRK; end
         else if (cmd_prev == 2 && floor_i > 0) begin ph = "release"; up = 1'b0; timer = BRK; end
         else if (cmd_prev == 3) begin ph = "door"; timer = DOORC; end
      end else if (ph == "release") begin
         if (stop) ph = "decel";
         else begin timer--; if (timer == 0) ph = "accel"; end
      end else if (ph == "accel") begin
         if (stop) ph = "decel";
         else begin
            duty = (duty + STEP > DMAX) ? DMAX : duty + STEP;
            if (duty == DMAX) ph = "run";
         end
      end else if (ph == "run") begin
         if (stop) ph = "decel";
      end else if (ph == "decel") begin
         duty = (duty - STEP < 0) ? 0 : duty - STEP;
         if (duty == 0) begin ph = "hold"; timer = BRK; end
      end else if (ph == "hold" || ph == "door") begin
         timer--;
         if (timer == 0) ph = "idle";
      end

`ifdef LIFT_MOTION_WDOG_EN
      if (moving && !fe) begin
         quiet++;
         if (quiet == WDOG) begin ph = "fault"; duty = 0; end
      end else begin
         quiet = 0;
      end
`endif

      e_pwm   = (pwm_cnt < duty);
      pwm_cnt = (pwm_cnt + 1) % 256;
      h3 = h2; h2 = h1; h1 = fp;
      cmd_prev = c;
   endtask

   task automatic compare_all();
      check("motor_pwm", motor_pwm, e_pwm);
      check("motor_dir", motor_dir, up);
      check("brake",     brake, (ph == "idle") || (ph == "hold") || (ph == "door") || (ph == "fault"));
      check("door_open", door_open, ph == "door");
      check("cur_floor", cur_floor, floor_i);
      check("busy",      busy, ph != "idle");
      check("fault",     fault, ph == "fault");
   endtask

   // Inputs are stable here; they change only after this task returns.
   task automatic tick();
      int c;
      bit fp;
      c  = int'(motor_signal);
      fp = floor_pulse;
      @(posedge clk);
      if (rst) m_step(c, fp);
      else     m_reset();
      #1;
      compare_all();
   endtask

   task automatic pulse();
      floor_pulse = 1'b1;
      repeat (3) tick();
      floor_pulse = 1'b0;
      repeat (3) tick();
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while (busy === 1'b1 && i < budget) begin
         tick();
         i++;
      end
      check("idle_within_budget", busy, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n_open, n_high, hold, i;
      m_reset();

      // Reset values.
      repeat (3) tick();
      check("rst.brake", brake, 1);
      check("rst.pwm", motor_pwm, 0);
      check("rst.busy", busy, 0);
      check("rst.floor", cur_floor, 0);
      check("rst.door", door_open, 0);
      check("rst.dir", motor_dir, 0);
      check("rst.fault", fault, 0);
      rst = 1'b1;

      // DOWN at floor 0 is ignored.
      tag = "down_at_0";
      motor_signal = C_DOWN;
      repeat (10) tick();
      check("busy", busy, 0);
      check("brake", brake, 1);

      // UP from floor 0: brake releases two clocks after the command.
      tag = "up_from_0";
      motor_signal = C_UP;
      tick();
      check("brake_1clk", brake, 1);
      tick();
      check("brake_2clk", brake, 0);
      check("dir", motor_dir, 1);
      repeat (BRK + DMAX / STEP) tick();
      n_high = 0;
      for (int k = 0; k < 256; k++) begin
         tick();
         if (motor_pwm) n_high++;
      end
      check("run_duty", n_high, DMAX);
      repeat (3) pulse();
      check("floor3", cur_floor, 3);
      motor_signal = C_STOP;
      wait_idle(300);
      check("stop.brake", brake, 1);
      check("stop.pwm", motor_pwm, 0);
      check("stop.floor", cur_floor, 3);

      // UP to the top floor: arrival forces a stop although UP persists.
      tag = "up_to_top";
      motor_signal = C_UP;
      repeat (20) tick();
      repeat (6) pulse();
      check("floor9", cur_floor, 9);
      pulse();
      check("floor10", cur_floor, 10);
      pulse();
      check("floor10_sat", cur_floor, 10);
      wait_idle(300);
      check("floor_final", cur_floor, 10);
      repeat (10) tick();
      check("up_at_top_ignored", busy, 0);

      // DOOR: open for exactly DOORC cycles; a motion command waits for IDLE.
      tag = "door";
      motor_signal = C_DOOR;
      n_open = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (door_open) n_open++;
         if (k == 5) motor_signal = C_DOWN;
      end
      check("open_cycles", n_open, DOORC);
      check("dir_after_door", motor_dir, 0);
      check("moving_after_door", busy, 1);
      repeat (5) pulse();
      check("floor5", cur_floor, 5);
      motor_signal = C_STOP;
      wait_idle(300);

      // Reversal from RUN: direction flips only after passing through IDLE.
      tag = "reverse";
      motor_signal = C_UP;
      repeat (80) tick();
      motor_signal = C_DOWN;
      i = 0;
      while (busy === 1'b1 && i < 300) begin
         check("dir_held", motor_dir, 1);
         tick();
         i++;
      end
      check("idle_reached", busy, 0);
      tick();
      check("dir_flipped", motor_dir, 0);
      check("brake_released", brake, 0);
      repeat (30) tick();
      pulse();
      check("floor4", cur_floor, 4);
      motor_signal = C_STOP;
      wait_idle(300);

      // Randomised commands and floor pulses.
      tag = "random";
      for (int s = 0; s < 40; s++) begin
         motor_signal = 2'($urandom_range(0, 3));
         hold = $urandom_range(1, 120);
         for (int k = 0; k < hold; k++) begin
            if ($urandom_range(0, 7) == 0) floor_pulse = ~floor_pulse;
            tick();
         end
      end
      floor_pulse  = 1'b0;
      motor_signal = C_STOP;
      wait_idle(400);

      // Asynchronous reset in the middle of travel.
      tag = "async_rst";
      motor_signal = (floor_i < MAXF) ? C_UP : C_DOWN;
      repeat (40) tick();
      check("moving", busy, 1);
      #2 rst = 1'b0;
      m_reset();
      #1;
      check("brake", brake, 1);
      check("pwm", motor_pwm, 0);
      check("busy", busy, 0);
      check("floor", cur_floor, 0);
      motor_signal = C_STOP;
      repeat (2) tick();
      rst = 1'b1;
      repeat (4) tick();

`ifdef LIFT_MOTION_WDOG_EN
      // Watchdog: travel with no floor pulses latches the fault until reset.
      tag = "wdog";
      motor_signal = C_UP;
      repeat (4200) tick();
      check("fault", fault, 1);
      check("brake", brake, 1);
      check("pwm", motor_pwm, 0);
      motor_signal = C_STOP;
      repeat (20) tick();
      check("fault_sticky", fault, 1);
      rst = 1'b0;
      tick();
      check("fault_cleared", fault, 0);
      rst = 1'b1;
      repeat (2) tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
